// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and datapath-select encodings shared by the control unit and datapath
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MW    = 4'd4,
    S_WBM   = 4'd5,
    S_EXE   = 4'd6,
    S_WBR   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;

  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;
  localparam logic [1:0] GPR_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_sub;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;
  } dec_t;
endpackage

// File: rtl/ctrl_dec.sv
// ctrl_dec: opcode/funct to instruction-class decoder
module ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);
  // is_r only covers R-type functs the datapath implements; others fall out as NOPs
  always_comb begin
    dec        = '0;
    dec.is_r   = opcode == OP_RTYPE && (funct == FN_ADDU || funct == FN_SUBU);
    dec.is_sub = opcode == OP_RTYPE && funct == FN_SUBU;
    dec.is_ori = opcode == OP_ORI;
    dec.is_lui = opcode == OP_LUI;
    dec.is_lw  = opcode == OP_LW;
    dec.is_sw  = opcode == OP_SW;
    dec.is_beq = opcode == OP_BEQ;
    dec.is_j   = opcode == OP_J;
    dec.is_jal = opcode == OP_JAL;
  end
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle Moore control unit sequencing IR, PC, register file, ALU and data memory
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IRWr,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] ALUOp,
  output logic [1:0] EXTOp,
  output logic       BSel,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel
);
  state_e state_q, state_d;
  dec_t   dec;

  ctrl_dec u_dec (
    .opcode(opcode),
    .funct (funct),
    .dec   (dec)
  );

  // state register; reset parks the machine in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next-state: undecoded instructions and illegal state codes return to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD:   state_d = (dec.is_lw || dec.is_sw)                ? S_MA  :
                         (dec.is_r || dec.is_ori || dec.is_lui)  ? S_EXE :
                         dec.is_beq                              ? S_BR  :
                         (dec.is_j || dec.is_jal)                ? S_JMP : S_FETCH;
      S_MA:    state_d = dec.is_lw ? S_MR : S_MW;
      S_MR:    state_d = S_WBM;
      S_EXE:   state_d = S_WBR;
      default: state_d = S_FETCH;
    endcase
  end

  // Moore outputs; rst_n low forces everything to 0 so an aborted write drops at once
  always_comb begin
    IRWr   = 1'b0;
    PCWr   = 1'b0;
    NPCOp  = NPC_PC4;
    RFWr   = 1'b0;
    DMWr   = 1'b0;
    ALUOp  = ALU_ADD;
    EXTOp  = EXT_ZERO;
    BSel   = 1'b0;
    GPRSel = GPR_RD;
    WDSel  = WD_ALU;
    case (state_q)
      S_FETCH: begin
        IRWr  = 1'b1;
        PCWr  = 1'b1;
        NPCOp = NPC_PC4;
      end
      S_MA, S_MR: begin
        ALUOp = ALU_ADD;
        BSel  = 1'b1;
        EXTOp = EXT_SIGN;
      end
      S_WBM: begin
        RFWr   = 1'b1;
        GPRSel = GPR_RT;
        WDSel  = WD_DM;
      end
      S_MW: DMWr = 1'b1;
      S_EXE, S_WBR: begin
        ALUOp = dec.is_sub ? ALU_SUB : dec.is_ori ? ALU_OR : dec.is_lui ? ALU_PASSB : ALU_ADD;
        BSel  = dec.is_ori || dec.is_lui;
        EXTOp = dec.is_lui ? EXT_HI : EXT_ZERO;
        if (state_q == S_WBR) begin
          RFWr   = 1'b1;
          WDSel  = WD_ALU;
          GPRSel = dec.is_r ? GPR_RD : GPR_RT;
        end
      end
      S_BR: begin
        ALUOp = ALU_SUB;
        BSel  = 1'b0;
        NPCOp = NPC_BR;
        PCWr  = zero;
        EXTOp = EXT_SIGN;
      end
      S_JMP: begin
        PCWr  = 1'b1;
        NPCOp = NPC_J;
        if (dec.is_jal) begin
          RFWr   = 1'b1;
          GPRSel = GPR_RA;
          WDSel  = WD_PC;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      IRWr   = 1'b0;
      PCWr   = 1'b0;
      NPCOp  = 2'b00;
      RFWr   = 1'b0;
      DMWr   = 1'b0;
      ALUOp  = 2'b00;
      EXTOp  = 2'b00;
      BSel   = 1'b0;
      GPRSel = 2'b00;
      WDSel  = 2'b00;
    end
  end
endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multicycle control unit for the MIPS subset core: a Moore state machine that sequences the instruction register, PC, register file, ALU and data memory over 3–5 cycles per instruction. It issues the IR write strobe in FETCH, decodes the latched `opcode`/`funct` returned by the instruction register, and drives every datapath write enable and mux select. It is the only source of `IRWr`, `PCWr`, `RFWr` and `DMWr` in the core.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DCD onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (rs == rt compare in BR)
- IRWr  out  1  instruction register load
- PCWr  out  1  PC load
- NPCOp  out  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target
- RFWr  out  1  register file write
- DMWr  out  1  data memory write
- ALUOp  out  2  00 add, 01 sub, 10 or, 11 pass B
- EXTOp  out  2  00 zero-extend, 01 sign-extend, 10 imm16<<16
- BSel  out  1  ALU B operand: 0 register rt, 1 extended immediate
- GPRSel  out  2  write register: 00 rd, 01 rt, 10 $31
- WDSel  out  2  write data: 00 ALU result, 01 DM read data, 10 PC

## Operation
- Decoded opcodes: R-type 000000 (funct addu 100001, subu 100011), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States (4-bit): FETCH=0, DCD=1, MA=2, MR=3, MW=4, WBM=5, EXE=6, WBR=7, BR=8, JMP=9; codes 10–15 are illegal and return to FETCH.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state DCD.
- DCD: no writes. Next state: lw/sw→MA; R-type/ori/lui→EXE; beq→BR; j/jal→JMP; any other opcode, or R-type with an undecoded funct→FETCH (treated as NOP).
- MA: ALUOp=00, BSel=1, EXTOp=01. lw→MR, sw→MW.
- MR: select holds from MA. Next state WBM.
- WBM: RFWr=1, GPRSel=01, WDSel=01. Next state FETCH.
- MW: DMWr=1. Next state FETCH.
- EXE: addu ALUOp=00/BSel=0; subu 01/0; ori 10/1 EXTOp=00; lui 11/1 EXTOp=10. Next state WBR.
- WBR: EXE selects held; RFWr=1, WDSel=00, GPRSel=00 for R-type, otherwise 01. Next state FETCH.
- BR: ALUOp=01, BSel=0, NPCOp=01, PCWr=zero, EXTOp=01. Next state FETCH.
- JMP: PCWr=1, NPCOp=10; for jal also RFWr=1, GPRSel=10, WDSel=10 (PC already holds PC+4). Next state FETCH.
- Unlisted outputs are 0 in every state.

## Timing
- Cycles per instruction: lw 5; sw, R-type, ori and lui 4; beq, j and jal 3; undecoded instruction 2.
- Outputs are combinational from the state register and the latched IR fields; there are no combinational paths from `zero` except to PCWr in BR.
- Reset: state=FETCH asynchronously. While rst_n=0, IRWr, PCWr, RFWr and DMWr are forced 0 and all selects read 0.
- On the first rising edge after rst_n deasserts, FETCH is active with IRWr=1.
- Reset asserted mid-instruction aborts it immediately. Any write enable active in that cycle drops the same instant.
- At most one of RFWr/DMWr is high in any cycle. IRWr is high only in FETCH.

## Structure
- `ctrl_pkg` holds the state encodings, opcode/funct constants, and the NPCOp/ALUOp/EXTOp/GPRSel/WDSel encodings. The ALU, EXT, NPC and mux blocks import the same package.
- One natural sub-module: `ctrl_dec`, a combinational opcode/funct → instruction-class decoder (is_rtype, is_lw, is_sw, …) feeding both next-state and output logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → all enables 0 during reset; IRWr=1, PCWr=1 in the first cycle after release.
- lw (opcode 100011): states go FETCH→DCD→MA→MR→WBM. In WBM, RFWr=1, GPRSel=01, WDSel=01; next cycle IRWr=1.
- sw then addu: DMWr=1 for exactly one cycle in MW. For addu (funct 100001), RFWr=1 with GPRSel=00 in cycle 4 and DMWr never high.
- beq with zero=1, then zero=0: BR asserts PCWr=1, NPCOp=01 in the first case and PCWr=0 in the second; both instructions take 3 cycles.
- jal (000011): JMP drives PCWr=1, NPCOp=10, RFWr=1, GPRSel=10, WDSel=10. j drives the same except RFWr=0.
- Illegal opcode 111111 → DCD→FETCH with no RFWr/DMWr/PCWr pulse. Pulling rst_n low during MR of a lw → state returns to FETCH and RFWr never asserts.
